microwave_cook_ctrl: RTL and testbench

Cook-cycle sequencer for the microwave oven FSM. It holds the programmed cook time and issues the `start` and `finish` inputs that the oven FSM consumes. It counts the time down on a 1 Hz tick only while the oven reports heating, and gates the magnetron with a power-level duty cycle. It sits between the front-panel decoder and the oven FSM, and its `mag_en` output is the only signal that drives the magnetron.

---
 rtl/microwave_pkg.sv | 52 +++++
 rtl/sat_sec_counter.sv | 53 +++++
 rtl/microwave_cook_ctrl.sv | 159 +++++++++++++++
 tb/tb_microwave_cook_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
`default_nettype none
// ============================================================================
// Module   : microwave_pkg
// Purpose  : Shared types and constants for the microwave cook-cycle logic:
//            sequencer states, time/duty limits, oven FSM state codes and
//            small saturating-arithmetic helpers.
// Revision : 1.0 - initial release
// ============================================================================
package microwave_pkg;

   // Longest programmable cook time, 59:59
   localparam int MAX_SECS   = 3599;
   // Duty window length in heated seconds
   localparam int WIN        = 10;
   // Power level used when the front panel reports 0 or an out-of-range value
   localparam int FULL_POWER = 10;
   // Cook time loaded by a start press with nothing programmed
   localparam int QUICK_SECS = 30;

   // Cook-cycle sequencer states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_RUNNING = 2'd2,
      ST_DONE    = 2'd3
   } cook_state_t;

   // Oven FSM state codes, shared so both FSMs agree on one definition
   typedef enum logic [1:0] {
      OVEN_IDLE  = 2'd0,
      OVEN_COOK  = 2'd1,
      OVEN_PAUSE = 2'd2,
      OVEN_BELL  = 2'd3
   } oven_state_t;

   // Clamp a 13-bit seconds value to the programmable range
   function automatic logic [11:0] clamp_secs(input logic [12:0] v);
      return (v > 13'(MAX_SECS)) ? 12'(MAX_SECS) : v[11:0];
   endfunction

   // Add the quick-add increment with saturation
   function automatic logic [11:0] sat_add30(input logic [11:0] v);
      return clamp_secs({1'b0, v} + 13'(QUICK_SECS));
   endfunction

   // Map the front-panel power code onto 1..10
   function automatic logic [3:0] norm_power(input logic [3:0] p);
      return ((p == 4'd0) || (p > 4'(FULL_POWER))) ? 4'(FULL_POWER) : p;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sat_sec_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_sec_counter
// Purpose  : 12-bit seconds register with clear, load, saturating +30 and
//            decrement-to-zero, plus a zero flag for the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module sat_sec_counter
   import microwave_pkg::*;
(
   input  logic        clk,
   input  logic        nrst,
   input  logic        i_clr,
   input  logic        i_load,
   input  logic [11:0] i_load_val,
   input  logic        i_add30,
   input  logic        i_dec,
   output logic [11:0] o_count,
   output logic        o_zero
);

   logic [11:0] r_count;
   logic [11:0] w_sum;
   logic [11:0] w_next;

   // Next count: clear beats load beats add/decrement; add and decrement
   // may coincide, and the decrement never wraps below zero
   always_comb begin
      w_sum  = i_add30 ? sat_add30(r_count) : r_count;
      w_next = w_sum;
      if (i_clr) begin
         w_next = '0;
      end else if (i_load) begin
         w_next = clamp_secs({1'b0, i_load_val});
      end else if (i_dec && (w_sum != '0)) begin
         w_next = w_sum - 12'd1;
      end
   end

   // Count register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_count <= '0;
      end else begin
         r_count <= w_next;
      end
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/microwave_cook_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : microwave_cook_ctrl
// Purpose  : Cook-cycle sequencer. Holds the programmed time, issues start /
//            finish to the oven FSM, counts down on heated seconds and gates
//            the magnetron with a power-level duty window.
// Revision : 1.0 - initial release
// ============================================================================
module microwave_cook_ctrl
   import microwave_pkg::*;
(
   input  logic        clk,
   input  logic        nrst,
   input  logic        tick,
   input  logic        set_valid,
   input  logic [11:0] set_secs,
   input  logic        add30,
   input  logic        start_btn,
   input  logic        cancel_btn,
   input  logic [3:0]  power,
   input  logic        door,
   input  logic        heat_in,
   output logic        start,
   output logic        finish,
   output logic        mag_en,
   output logic [11:0] remaining,
   output logic        busy
);

   localparam logic [3:0]  c_win_last   = 4'(WIN - 1);
   localparam logic [11:0] c_quick_secs = 12'(QUICK_SECS);

   cook_state_t r_state;
   cook_state_t w_state_next;
   logic [3:0]  r_win;
   logic [3:0]  w_win_next;
   logic [3:0]  r_pwr;
   logic [3:0]  w_pwr_next;
   logic        r_door_q;
   logic        w_start_next;
   logic        w_heated_tick;
   logic [11:0] w_v;

   logic        w_cnt_clr;
   logic        w_cnt_load;
   logic        w_cnt_add;
   logic        w_cnt_dec;
   logic        w_cnt_zero;

   // A second only counts while the oven is actually heating
   assign w_heated_tick = tick & heat_in;

   sat_sec_counter u_secs (
      .clk        (clk),
      .nrst       (nrst),
      .i_clr      (w_cnt_clr),
      .i_load     (w_cnt_load),
      .i_load_val (w_v),
      .i_add30    (w_cnt_add),
      .i_dec      (w_cnt_dec),
      .o_count    (remaining),
      .o_zero     (w_cnt_zero)
   );

   // Next-state, counter commands and duty bookkeeping
   always_comb begin
      w_state_next = r_state;
      w_win_next   = r_win;
      w_pwr_next   = r_pwr;
      w_start_next = 1'b0;
      w_cnt_clr    = 1'b0;
      w_cnt_load   = 1'b0;
      w_cnt_add    = 1'b0;
      w_cnt_dec    = 1'b0;
      w_v          = remaining;

      case (r_state)
         ST_IDLE, ST_ARMED: begin
            if (cancel_btn) begin
               w_cnt_clr    = 1'b1;
               w_state_next = ST_IDLE;
            end else begin
               if (set_valid) begin
                  w_v = clamp_secs({1'b0, set_secs});
               end else if (add30) begin
                  w_v = sat_add30(remaining);
               end
               if (start_btn && !door) begin
                  // Nothing programmed: quick start with 30 s
                  if (w_v == '0) begin
                     w_v = c_quick_secs;
                  end
                  w_cnt_load   = 1'b1;
                  w_state_next = ST_RUNNING;
                  w_start_next = 1'b1;
                  w_pwr_next   = norm_power(power);
                  w_win_next   = '0;
               end else if (set_valid || add30) begin
                  w_cnt_load   = 1'b1;
                  w_state_next = (w_v == '0) ? ST_IDLE : ST_ARMED;
               end else begin
                  w_state_next = w_cnt_zero ? ST_IDLE : ST_ARMED;
               end
            end
         end

         ST_RUNNING: begin
            if (cancel_btn) begin
               w_cnt_clr    = 1'b1;
               w_state_next = ST_DONE;
            end else if (w_heated_tick && (remaining == 12'd1)) begin
               // Completing second wins over a same-cycle quick-add
               w_cnt_dec    = 1'b1;
               w_state_next = ST_DONE;
            end else begin
               w_cnt_add = add30;
               w_cnt_dec = w_heated_tick;
               if (w_heated_tick) begin
                  w_win_next = (r_win == c_win_last) ? 4'd0 : r_win + 4'd1;
               end
            end
         end

         ST_DONE: begin
            // Leave only once the user opens the door
            if (door && !r_door_q) begin
               w_state_next = ST_IDLE;
            end
         end

         default: w_state_next = ST_IDLE;
      endcase
   end

   // State, duty registers and registered outputs
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state  <= ST_IDLE;
         r_win    <= '0;
         r_pwr    <= 4'(FULL_POWER);
         r_door_q <= 1'b0;
         start    <= 1'b0;
         finish   <= 1'b0;
         busy     <= 1'b0;
         mag_en   <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_win    <= w_win_next;
         r_pwr    <= w_pwr_next;
         r_door_q <= door;
         start    <= w_start_next;
         finish   <= (w_state_next == ST_DONE);
         busy     <= (w_state_next == ST_RUNNING) || (w_state_next == ST_DONE);
         mag_en   <= (w_state_next == ST_RUNNING) && heat_in && (w_win_next < w_pwr_next);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_microwave_cook_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_microwave_cook_ctrl
// Purpose  : Self-checking bench for microwave_cook_ctrl with a small oven
//            FSM, a cycle-level behavioural model and directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_microwave_cook_ctrl;
   import microwave_pkg::*;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        tick = 1'b0;
   logic        set_valid = 1'b0;
   logic [11:0] set_secs = '0;
   logic        add30 = 1'b0;
   logic        start_btn = 1'b0;
   logic        cancel_btn = 1'b0;
   logic [3:0]  power = 4'd10;
   logic        door = 1'b0;
   logic        heat_in;
   logic        start, finish, mag_en, busy;
   logic [11:0] remaining;

   int checks = 0;
   int failures = 0;
   logic cmp_en = 1'b0;

   always #5 clk = ~clk;

   microwave_cook_ctrl dut (
      .clk        (clk),
      .nrst       (nrst),
      .tick       (tick),
      .set_valid  (set_valid),
      .set_secs   (set_secs),
      .add30      (add30),
      .start_btn  (start_btn),
      .cancel_btn (cancel_btn),
      .power      (power),
      .door       (door),
      .heat_in    (heat_in),
      .start      (start),
      .finish     (finish),
      .mag_en     (mag_en),
      .remaining  (remaining),
      .busy       (busy)
   );

   // Oven FSM stand-in: heat is a registered copy of being in COOK
   oven_state_t ov;
   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ov      <= OVEN_IDLE;
         heat_in <= 1'b0;
      end else begin
         heat_in <= (ov == OVEN_COOK);
         case (ov)
            OVEN_IDLE:  if (start && !door) ov <= OVEN_COOK;
            OVEN_COOK:  if (finish) ov <= OVEN_BELL; else if (door) ov <= OVEN_PAUSE;
            OVEN_PAUSE: if (!door) ov <= OVEN_COOK;
            default:    if (door) ov <= OVEN_IDLE;
         endcase
      end
   end

   // Behavioural model: phase, seconds left, heated seconds since start
   localparam int P_IDLE = 0, P_ARMED = 1, P_RUN = 2, P_DONE = 3;
   typedef struct packed {
      int   phase;
      int   secs;
      int   pwr;
      int   heated;
      logic door_q;
      logic start;
      logic finish;
      logic busy;
      logic mag;
   } model_t;
   model_t m;

   function automatic int min_max(input int v);
      return (v > MAX_SECS) ? MAX_SECS : v;
   endfunction

   function automatic model_t model_reset();
      model_t r;
      r     = '0;
      r.pwr = 10;
      return r;
   endfunction

   function automatic model_t model_step(input model_t c, input logic tk, input logic sv,
                                         input logic [11:0] ss, input logic a30, input logic sb,
                                         input logic cb, input logic [3:0] pw, input logic dr,
                                         input logic ht);
      model_t n;
      int v;
      n = c;
      n.start = 1'b0;
      if (c.phase == P_IDLE || c.phase == P_ARMED) begin
         if (cb) begin
            n.secs  = 0;
            n.phase = P_IDLE;
         end else begin
            v = c.secs;
            if (sv) v = min_max(int'(ss));
            else if (a30) v = min_max(c.secs + 30);
            if (sb && !dr) begin
               n.secs   = (v == 0) ? 30 : v;
               n.phase  = P_RUN;
               n.start  = 1'b1;
               n.pwr    = (pw == 0 || pw > 10) ? 10 : int'(pw);
               n.heated = 0;
            end else begin
               n.secs  = v;
               n.phase = (v > 0) ? P_ARMED : P_IDLE;
            end
         end
      end else if (c.phase == P_RUN) begin
         if (cb) begin
            n.secs  = 0;
            n.phase = P_DONE;
         end else if (tk && ht) begin
            if (c.secs == 1) begin
               n.secs  = 0;
               n.phase = P_DONE;
            end else begin
               n.secs   = min_max(c.secs + (a30 ? 30 : 0)) - 1;
               n.heated = c.heated + 1;
            end
         end else if (a30) begin
            n.secs = min_max(c.secs + 30);
         end
      end else begin
         if (dr && !c.door_q) n.phase = P_IDLE;
      end
      n.door_q = dr;
      n.finish = (n.phase == P_DONE);
      n.busy   = (n.phase == P_RUN) || (n.phase == P_DONE);
      n.mag    = (n.phase == P_RUN) && ht && ((n.heated % WIN) < n.pwr);
      return n;
   endfunction

   // Model advances on the same edges as the DUT, reset included
   always @(posedge clk or negedge nrst) begin
      if (!nrst) m <= model_reset();
      else m <= model_step(m, tick, set_valid, set_secs, add30, start_btn, cancel_btn,
                           power, door, heat_in);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (cmp_en) begin
         check("model.start",     32'(start),     32'(m.start));
         check("model.finish",    32'(finish),    32'(m.finish));
         check("model.busy",      32'(busy),      32'(m.busy));
         check("model.mag_en",    32'(mag_en),    32'(m.mag));
         check("model.remaining", 32'(remaining), 32'(m.secs));
      end
   end

   // Event counters used by the directed scenarios
   int starts = 0;
   int mag_cycles = 0;
   always @(negedge clk) begin
      if (start === 1'b1) starts++;
      if (mag_en === 1'b1) mag_cycles++;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_set(input int s);
      set_secs  = 12'(s);
      set_valid = 1'b1;
      step(1);
      set_valid = 1'b0;
   endtask

   task automatic pulse_add();
      add30 = 1'b1;
      step(1);
      add30 = 1'b0;
   endtask

   task automatic pulse_start();
      start_btn = 1'b1;
      step(1);
      start_btn = 1'b0;
   endtask

   task automatic pulse_cancel();
      cancel_btn = 1'b1;
      step(1);
      cancel_btn = 1'b0;
   endtask

   // n ticks two cycles apart; counts ticks that find the magnetron on
   task automatic ticks(input int n, output int on);
      on = 0;
      repeat (n) begin
         if (mag_en === 1'b1) on++;
         tick = 1'b1;
         step(1);
         tick = 1'b0;
         step(2);
      end
   endtask

   task automatic door_cycle();
      door = 1'b1;
      step(2);
      door = 1'b0;
      step(2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int on, s0, mc0;
      step(3);
      @(negedge clk);
      nrst = 1'b1;
      cmp_en = 1'b1;
      step(1);
      check("reset.remaining", 32'(remaining), 32'd0);
      check("reset.busy",      32'(busy),      32'd0);
      check("reset.finish",    32'(finish),    32'd0);
      check("reset.mag_en",    32'(mag_en),    32'd0);

      // 5 s at full power
      power = 4'd10;
      pulse_set(5);
      check("t1.loaded", 32'(remaining), 32'd5);
      s0 = starts;
      pulse_start();
      check("t1.start_hi", 32'(start), 32'd1);
      check("t1.busy",     32'(busy),  32'd1);
      step(1);
      check("t1.start_lo", 32'(start), 32'd0);
      step(2);
      ticks(5, on);
      check("t1.on_ticks",  32'(on),        32'd5);
      check("t1.finish",    32'(finish),    32'd1);
      check("t1.remaining", 32'(remaining), 32'd0);
      check("t1.mag_off",   32'(mag_en),    32'd0);
      check("t1.one_start", 32'(starts - s0), 32'd1);
      door = 1'b1;
      step(1);
      check("t1.door_idle", 32'(busy),   32'd0);
      check("t1.finish_lo", 32'(finish), 32'd0);
      door = 1'b0;
      step(2);

      // 20 s at power 3: 3 of every 10 heated seconds are on
      power = 4'd3;
      pulse_set(20);
      pulse_start();
      step(3);
      ticks(20, on);
      check("t2.on_secs", 32'(on),     32'd6);
      check("t2.finish",  32'(finish), 32'd1);
      door_cycle();

      // Pause at 10 s for 4 ticks, then finish after 10 more heated ticks
      power = 4'd10;
      pulse_set(14);
      pulse_start();
      step(3);
      ticks(4, on);
      check("t3.at10", 32'(remaining), 32'd10);
      door = 1'b1;
      step(4);
      ticks(4, on);
      check("t3.paused_on",  32'(on),        32'd0);
      check("t3.paused_rem", 32'(remaining), 32'd10);
      check("t3.paused_mag", 32'(mag_en),    32'd0);
      door = 1'b0;
      step(4);
      ticks(9, on);
      check("t3.rem1",     32'(remaining), 32'd1);
      check("t3.not_done", 32'(finish),    32'd0);
      ticks(1, on);
      check("t3.finish", 32'(finish), 32'd1);
      door_cycle();

      // Saturation and clamping
      pulse_set(3599);
      check("t4.max", 32'(remaining), 32'd3599);
      pulse_add();
      check("t4.add_sat", 32'(remaining), 32'd3599);
      pulse_set(4000);
      check("t4.clamp",      32'(remaining), 32'd3599);
      check("t4.armed_busy", 32'(busy),      32'd0);
      pulse_cancel();
      check("t4.cancel", 32'(remaining), 32'd0);

      // Add while running, then cancel while paused
      power = 4'd7;
      pulse_set(12);
      s0 = starts;
      pulse_start();
      step(3);
      pulse_add();
      check("t5.add_run", 32'(remaining), 32'd42);
      step(2);
      check("t5.one_start", 32'(starts - s0), 32'd1);
      door = 1'b1;
      step(4);
      pulse_cancel();
      check("t5.finish",    32'(finish),    32'd1);
      check("t5.remaining", 32'(remaining), 32'd0);
      check("t5.busy",      32'(busy),      32'd1);
      mc0 = mag_cycles;
      door = 1'b0;
      step(6);
      check("t5.oven_bell", 32'(ov),                32'(OVEN_BELL));
      check("t5.no_mag",    32'(mag_cycles - mc0),  32'd0);
      check("t5.held",      32'(finish),            32'd1);
      door = 1'b1;
      step(1);
      check("t5.idle", 32'(busy), 32'd0);
      door = 1'b0;
      step(2);

      // Power code 0 means full power; final tick + cancel + add30 together
      power = 4'd0;
      pulse_set(2);
      pulse_start();
      step(3);
      check("t6.full_pwr", 32'(mag_en), 32'd1);
      ticks(1, on);
      check("t6.rem1", 32'(remaining), 32'd1);
      tick = 1'b1;
      cancel_btn = 1'b1;
      add30 = 1'b1;
      step(1);
      tick = 1'b0;
      cancel_btn = 1'b0;
      add30 = 1'b0;
      check("t6.finish",    32'(finish),    32'd1);
      check("t6.remaining", 32'(remaining), 32'd0);
      step(2);
      door_cycle();

      // Reset in the middle of a cook
      power = 4'd4;
      pulse_set(50);
      pulse_start();
      step(3);
      ticks(2, on);
      #3;
      nrst = 1'b0;
      #1;
      check("t7.start",     32'(start),     32'd0);
      check("t7.finish",    32'(finish),    32'd0);
      check("t7.mag_en",    32'(mag_en),    32'd0);
      check("t7.busy",      32'(busy),      32'd0);
      check("t7.remaining", 32'(remaining), 32'd0);
      @(negedge clk);
      nrst = 1'b1;
      step(2);
      check("t7.idle_after", 32'(busy), 32'd0);
      pulse_set(3);
      check("t7.alive", 32'(remaining), 32'd3);
      step(2);

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
